// File: rtl/pe_pkg.sv
// Shared types and constants for the output-stationary PE family.
// Holds the FSM state encoding, accumulator sizing and rounding-mode codes.
package pe_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } pe_state_t;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_HALF_UP = 1;

   // Full-precision product plus guard bits so a long tile cannot wrap.
   function automatic int acc_width(input int width, input int guard);
      return 2 * width + guard;
   endfunction

endpackage

// File: rtl/pe_sat_round.sv
// Combinational round, arithmetic shift and clamp from accumulator width to result width.
// Raises sat whenever the clamp changes the value.
module pe_sat_round
   import pe_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int ACC_W      = 40,
   parameter int ROUND      = ROUND_HALF_UP
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [WIDTH-1:0] res,
   output logic                    sat
);

   // One extra bit keeps the rounding add from overflowing at full-scale accumulators.
   localparam int EXT_W = ACC_W + 1;

   localparam logic signed [EXT_W-1:0] RES_MAX = {{(EXT_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] RES_MIN = {{(EXT_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   function automatic logic signed [EXT_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
      logic signed [EXT_W-1:0] ext;
      logic signed [EXT_W-1:0] bias;
      ext  = {a[ACC_W-1], a};
      bias = '0;
      if (ROUND == ROUND_HALF_UP)
         bias[FRAC_WIDTH-1] = 1'b1;
      return (ext + bias) >>> FRAC_WIDTH;
   endfunction

   logic signed [EXT_W-1:0] shifted;

   always_comb begin
      shifted = round_shift(acc);
      res     = shifted[WIDTH-1:0];
      sat     = 1'b0;
      if (shifted > RES_MAX) begin
         res = RES_MAX[WIDTH-1:0];
         sat = 1'b1;
      end else if (shifted < RES_MIN) begin
         res = RES_MIN[WIDTH-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/pe_os_drain.sv
// Output-stationary systolic PE: K-term MAC tile, one-shot round/saturate at completion,
// and a per-column drain chain that ships finished results while the next tile runs.
module pe_os_drain
   import pe_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int GUARD      = 8,
   parameter int MAX_K      = 256,
   parameter int ROUND      = ROUND_HALF_UP,
   localparam int ACC_W     = acc_width(WIDTH, GUARD),
   localparam int KW        = $clog2(MAX_K + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [WIDTH-1:0] in_west,
   input  logic                    in_west_valid,
   input  logic signed [WIDTH-1:0] in_north,
   input  logic                    in_north_valid,
   input  logic        [KW-1:0]    k_len,
   input  logic                    acc_clear,
   output logic signed [WIDTH-1:0] out_east,
   output logic                    out_east_valid,
   output logic signed [WIDTH-1:0] out_south,
   output logic                    out_south_valid,
   input  logic                    drain_en,
   input  logic signed [WIDTH-1:0] drain_in,
   input  logic                    drain_in_valid,
   output logic signed [WIDTH-1:0] drain_out,
   output logic                    drain_out_valid,
   output logic                    busy,
   output logic                    err_sat,
   output logic                    err_mismatch,
   output logic                    err_overrun
);

   pe_state_t                state, state_nxt;
   logic signed [ACC_W-1:0]  acc, acc_nxt;
   logic        [KW-1:0]     cnt, cnt_nxt, cnt_inc;
   logic        [KW-1:0]     k_eff, k_eff_nxt, k_first;
   logic signed [WIDTH-1:0]  res_q;
   logic                     pending;

   logic                     mac, mismatch, capture;
   logic signed [2*WIDTH-1:0] prod_p0;
   logic signed [ACC_W-1:0]  prod_ext_p0;
   logic signed [ACC_W-1:0]  acc_sum_p0;
   logic signed [WIDTH-1:0]  res_sat_p0;
   logic                     sat_p0;

   assign mac         = in_west_valid && in_north_valid;
   assign mismatch    = in_west_valid ^ in_north_valid;
   assign prod_p0     = in_west * in_north;
   assign prod_ext_p0 = {{GUARD{prod_p0[2*WIDTH-1]}}, prod_p0};
   // acc is zero in IDLE, so this sum is also the first-MAC value.
   assign acc_sum_p0  = acc + prod_ext_p0;
   assign cnt_inc     = cnt + KW'(1);
   assign k_first     = (k_len == '0) ? KW'(1) : k_len;

   pe_sat_round #(
      .WIDTH      (WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .ACC_W      (ACC_W),
      .ROUND      (ROUND)
   ) u_sat_round (
      .acc (acc_sum_p0),
      .res (res_sat_p0),
      .sat (sat_p0)
   );

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      k_eff_nxt = k_eff;
      capture   = 1'b0;
      if (acc_clear) begin
         state_nxt = IDLE;
         acc_nxt   = '0;
         cnt_nxt   = '0;
      end else if (mac) begin
         case (state)
            IDLE: begin
               k_eff_nxt = k_first;
               if (k_first == KW'(1)) begin
                  capture = 1'b1;
                  acc_nxt = '0;
                  cnt_nxt = '0;
               end else begin
                  state_nxt = ACCUM;
                  acc_nxt   = acc_sum_p0;
                  cnt_nxt   = KW'(1);
               end
            end
            ACCUM: begin
               if (cnt_inc == k_eff) begin
                  capture   = 1'b1;
                  state_nxt = IDLE;
                  acc_nxt   = '0;
                  cnt_nxt   = '0;
               end else begin
                  acc_nxt = acc_sum_p0;
                  cnt_nxt = cnt_inc;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Stage boundary: accumulator, forwarding, result holding and drain registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc             <= '0;
         cnt             <= '0;
         k_eff           <= '0;
         busy            <= 1'b0;
         out_east        <= '0;
         out_east_valid  <= 1'b0;
         out_south       <= '0;
         out_south_valid <= 1'b0;
         res_q           <= '0;
         pending         <= 1'b0;
         drain_out       <= '0;
         drain_out_valid <= 1'b0;
         err_sat         <= 1'b0;
         err_mismatch    <= 1'b0;
         err_overrun     <= 1'b0;
      end else begin
         acc             <= acc_nxt;
         cnt             <= cnt_nxt;
         k_eff           <= k_eff_nxt;
         busy            <= (state_nxt == ACCUM);
         out_east        <= in_west;
         out_east_valid  <= in_west_valid;
         out_south       <= in_north;
         out_south_valid <= in_north_valid;

         if (drain_en) begin
            if (pending) begin
               drain_out       <= res_q;
               drain_out_valid <= 1'b1;
            end else begin
               drain_out       <= drain_in;
               drain_out_valid <= drain_in_valid;
            end
         end else begin
            drain_out_valid <= 1'b0;
         end

         // A drain of the held result frees the slot in the same cycle a new one lands.
         if (capture) begin
            if (sat_p0) err_sat <= 1'b1;
            if (pending && !drain_en) begin
               err_overrun <= 1'b1;
            end else begin
               res_q   <= res_sat_p0;
               pending <= 1'b1;
            end
         end else if (drain_en && pending) begin
            pending <= 1'b0;
         end

         if (mismatch) err_mismatch <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pe_os_drain.sv
// Directed bench for pe_os_drain: single PE (round and truncate builds) plus a 3-PE drain column.
module tb_pe_os_drain;

   localparam int W  = 16;
   localparam int KW = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [W-1:0]  west, north, drain_in;
   logic          wv, nv, acc_clear, drain_en, drain_in_valid;
   logic [KW-1:0] k_len;

   logic [W-1:0]  east, south, dout;
   logic          east_v, south_v, dout_v, busy, e_sat, e_mis, e_ovr;
   logic [W-1:0]  t_east, t_south, t_dout;
   logic          t_east_v, t_south_v, t_dout_v, t_busy, t_sat, t_mis, t_ovr;

   pe_os_drain #(.ROUND(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_west(west), .in_west_valid(wv), .in_north(north), .in_north_valid(nv),
      .k_len(k_len), .acc_clear(acc_clear),
      .out_east(east), .out_east_valid(east_v), .out_south(south), .out_south_valid(south_v),
      .drain_en(drain_en), .drain_in(drain_in), .drain_in_valid(drain_in_valid),
      .drain_out(dout), .drain_out_valid(dout_v), .busy(busy),
      .err_sat(e_sat), .err_mismatch(e_mis), .err_overrun(e_ovr)
   );

   pe_os_drain #(.ROUND(0)) u_trunc (
      .clk(clk), .rst_n(rst_n),
      .in_west(west), .in_west_valid(wv), .in_north(north), .in_north_valid(nv),
      .k_len(k_len), .acc_clear(acc_clear),
      .out_east(t_east), .out_east_valid(t_east_v), .out_south(t_south), .out_south_valid(t_south_v),
      .drain_en(drain_en), .drain_in(drain_in), .drain_in_valid(drain_in_valid),
      .drain_out(t_dout), .drain_out_valid(t_dout_v), .busy(t_busy),
      .err_sat(t_sat), .err_mismatch(t_mis), .err_overrun(t_ovr)
   );

   // Column of three PEs; index 0 is the top, index 2 feeds the column output.
   logic [W-1:0]  c_west [3];
   logic [W-1:0]  c_north[3];
   logic [W-1:0]  c_din  [3];
   logic [W-1:0]  c_dout [3];
   logic [W-1:0]  c_east [3];
   logic [W-1:0]  c_south[3];
   logic          c_din_v[3];
   logic          c_dout_v[3];
   logic          c_east_v[3], c_south_v[3], c_busy[3], c_sat[3], c_mis[3], c_ovr[3];
   logic          c_v, c_drain_en;
   logic [KW-1:0] c_klen;

   assign c_din[0]   = '0;
   assign c_din_v[0] = 1'b0;
   assign c_din[1]   = c_dout[0];
   assign c_din_v[1] = c_dout_v[0];
   assign c_din[2]   = c_dout[1];
   assign c_din_v[2] = c_dout_v[1];

   for (genvar i = 0; i < 3; i++) begin : g_col
      pe_os_drain #(.ROUND(1)) u_pe (
         .clk(clk), .rst_n(rst_n),
         .in_west(c_west[i]), .in_west_valid(c_v), .in_north(c_north[i]), .in_north_valid(c_v),
         .k_len(c_klen), .acc_clear(1'b0),
         .out_east(c_east[i]), .out_east_valid(c_east_v[i]),
         .out_south(c_south[i]), .out_south_valid(c_south_v[i]),
         .drain_en(c_drain_en), .drain_in(c_din[i]), .drain_in_valid(c_din_v[i]),
         .drain_out(c_dout[i]), .drain_out_valid(c_dout_v[i]), .busy(c_busy[i]),
         .err_sat(c_sat[i]), .err_mismatch(c_mis[i]), .err_overrun(c_ovr[i])
      );
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mac(input logic [W-1:0] w, input logic [W-1:0] n, input logic [KW-1:0] k);
      west = w; north = n; k_len = k; wv = 1'b1; nv = 1'b1;
      step();
      wv = 1'b0; nv = 1'b0;
   endtask

   task automatic drain_one();
      drain_en = 1'b1;
      step();
      drain_en = 1'b0;
   endtask

   initial begin
      west = '0; north = '0; wv = 0; nv = 0; k_len = '0; acc_clear = 0;
      drain_en = 0; drain_in = '0; drain_in_valid = 0;
      c_v = 0; c_drain_en = 0; c_klen = '0;
      for (int i = 0; i < 3; i++) begin c_west[i] = '0; c_north[i] = '0; end

      step(); step();
      check_vec("rst_dout", {dout_v, dout}, 32'h0);
      check_vec("rst_flags", {busy, e_sat, e_mis, e_ovr}, 32'h0);
      check_vec("rst_fwd", {east_v, east, south_v, south}, 32'h0);
      rst_n = 1'b1;
      step();

      // Basic k=1 tile: 1.5 * 2.0 = 3.0
      mac(16'h0180, 16'h0200, 9'd1);
      check_vec("fwd_east", {east_v, east}, {1'b1, 16'h0180});
      check_vec("fwd_south", {south_v, south}, {1'b1, 16'h0200});
      check_vec("basic_busy", busy, 0);
      drain_one();
      check_vec("basic_drain", {dout_v, dout}, {1'b1, 16'h0300});
      step();
      check_vec("drain_hold", {dout_v, dout}, {1'b0, 16'h0300});
      check_vec("basic_flags", {e_sat, e_mis, e_ovr}, 32'h0);

      // k=4 with bubbles: 4 * (1.0*1.0) = 4.0
      mac(16'h0100, 16'h0100, 9'd4);
      check_vec("accum_busy", busy, 1);
      west = 16'h1234; north = 16'h5678;
      step();
      check_vec("bubble_east", {east_v, east}, {1'b0, 16'h1234});
      check_vec("bubble_south", {south_v, south}, {1'b0, 16'h5678});
      mac(16'h0100, 16'h0100, 9'd4);
      step();
      mac(16'h0100, 16'h0100, 9'd4);
      check_vec("mid_busy", busy, 1);
      mac(16'h0100, 16'h0100, 9'd4);
      check_vec("done_busy", busy, 0);
      drain_one();
      check_vec("bubble_drain", {dout_v, dout}, {1'b1, 16'h0400});

      // Capture in the same cycle as draining the previous result
      mac(16'h0100, 16'h0200, 9'd1);
      west = 16'h0100; north = 16'h0600; wv = 1; nv = 1; drain_en = 1;
      step();
      wv = 0; nv = 0;
      check_vec("same_cyc_old", {dout_v, dout}, {1'b1, 16'h0200});
      check_vec("same_cyc_no_ovr", e_ovr, 0);
      step();
      drain_en = 0;
      check_vec("same_cyc_new", {dout_v, dout}, {1'b1, 16'h0600});

      // Overrun keeps the first result, then an empty PE passes drain_in through
      mac(16'h0100, 16'h0300, 9'd1);
      mac(16'h0100, 16'h0500, 9'd1);
      check_vec("overrun_flag", e_ovr, 1);
      drain_one();
      check_vec("overrun_keep", {dout_v, dout}, {1'b1, 16'h0300});
      drain_in = 16'h0ABC; drain_in_valid = 1;
      drain_one();
      check_vec("passthrough", {dout_v, dout}, {1'b1, 16'h0ABC});
      drain_in = '0; drain_in_valid = 0;

      // Saturation both directions
      check_vec("sat_pre", e_sat, 0);
      mac(16'h7FFF, 16'h7FFF, 9'd2);
      mac(16'h7FFF, 16'h7FFF, 9'd2);
      check_vec("sat_flag", e_sat, 1);
      drain_one();
      check_vec("sat_pos", {dout_v, dout}, {1'b1, 16'h7FFF});
      mac(16'h8000, 16'h7FFF, 9'd1);
      drain_one();
      check_vec("sat_neg", {dout_v, dout}, {1'b1, 16'h8000});

      // Half-LSB product: rounds up to 1, truncates to 0
      mac(16'h0001, 16'h0080, 9'd1);
      drain_one();
      check_vec("round_up", {dout_v, dout}, {1'b1, 16'h0001});
      check_vec("round_trunc", {t_dout_v, t_dout}, {1'b1, 16'h0000});

      // Abort mid-tile; the simultaneous MAC is dropped
      mac(16'h0100, 16'h0700, 9'd3);
      check_vec("clr_busy_pre", busy, 1);
      west = 16'h0100; north = 16'h0700; wv = 1; nv = 1; acc_clear = 1;
      step();
      wv = 0; nv = 0; acc_clear = 0;
      check_vec("clr_busy", busy, 0);
      mac(16'h0100, 16'h0200, 9'd1);
      drain_one();
      check_vec("clr_result", {dout_v, dout}, {1'b1, 16'h0200});

      // Single-valid cycle
      check_vec("mis_pre", e_mis, 0);
      west = 16'h0100; wv = 1; nv = 0;
      step();
      wv = 0;
      check_vec("mis_flag", e_mis, 1);
      check_vec("mis_no_mac", busy, 0);

      // Asynchronous reset mid-tile
      mac(16'h0100, 16'h0100, 9'd4);
      check_vec("rst_mid_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check_vec("rst_mid_dout", dout, 0);
      check_vec("rst_mid_ctrl", {busy, e_sat, e_mis, e_ovr, dout_v}, 32'h0);
      check_vec("rst_mid_fwd", {east_v, east}, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      mac(16'h0100, 16'h0100, 9'd1);
      drain_one();
      check_vec("rst_fresh", {dout_v, dout}, {1'b1, 16'h0100});

      // Column: three k=1 results drain bottom-first while the next tile accumulates
      for (int i = 0; i < 3; i++) begin
         c_west[i] = 16'h0100;
         c_north[i] = W'((i + 1) * 256);
      end
      c_klen = 9'd1; c_v = 1;
      step();
      for (int i = 0; i < 3; i++) c_north[i] = 16'h0100;
      c_klen = 9'd4; c_drain_en = 1;
      step();
      check_vec("col_first", {c_dout_v[2], c_dout[2]}, {1'b1, 16'h0300});
      step();
      check_vec("col_second", {c_dout_v[2], c_dout[2]}, {1'b1, 16'h0200});
      step();
      check_vec("col_third", {c_dout_v[2], c_dout[2]}, {1'b1, 16'h0100});
      c_v = 0;
      step();
      check_vec("col_empty", c_dout_v[2], 0);
      check_vec("col_busy", c_busy[2], 1);
      check_vec("col_no_ovr", c_ovr[2], 0);
      c_drain_en = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
